speed_level_ctrl: RTL
=====================

// Module: speed_level_ctrl
// PURPOSE
//  Consumer of the accel/decel pulses issued by the button auto-repeat front end.
//  Holds the current speed level and clamps it to a gear-dependent ceiling.
//  Applies engine-brake decay after a downshift and requests a limit beep.
//  Ramps a servo duty command toward the level; the PWM generator and FND/LED drivers read its outputs.
// PARAMETERS
//  MAX_LEVEL   15  absolute speed-level ceiling (4-bit)
//  GEAR_STEP   2   levels added per gear above 1
//  DUTY_STEP   16  duty counts per speed level (duty_tgt = level*DUTY_STEP, 8-bit, saturate 255)
//  RAMP_TICKS  4   tick_1khz periods per 1-count duty step
//  DECAY_TICKS 200 tick_1khz periods per 1-level engine-brake decay
// PORTS
//  clk_50mhz    in   1  system clock
//  rst          in   1  synchronous, active-high reset
//  tick_1khz    in   1  one-cycle enable, 1 kHz, from clock divider
//  accel_pulse  in   1  one-cycle increment request (auto-repeat output)
//  decel_pulse  in   1  one-cycle decrement request
//  gear_sw      in   3  gear select 0..7, raw switch, sampled every cycle
//  speed_level  out  4  current level 0..max_level
//  max_level    out  4  registered ceiling for current gear
//  overspeed    out  1  high while speed_level > max_level (decay active)
//  limit_beep   out  1  one-cycle pulse: request rejected at a limit
//  duty_cmd     out  8  ramped servo duty
//  ramp_busy    out  1  high while duty_cmd != duty_tgt
// BEHAVIOUR
//  Reset: speed_level=0, max_level=0, overspeed=0, limit_beep=0, duty_cmd=0, ramp_busy=0, FSM=HOLD, all tick counters=0.
//  Gear ceiling: g=0 -> 0; g>=1 -> min(MAX_LEVEL, 1+GEAR_STEP*(g-1)). Defaults: g1=1, g6=11, g7=13.
//   Ceiling is registered; it lags gear_sw by 1 cycle.
//  Pulse handling: evaluated every clk cycle, not gated by tick; speed_level updates on the next edge (1-cycle latency).
//   accel only:
//    - speed_level<max_level and !overspeed -> +1.
//    - Otherwise (at limit or overspeed) -> no change, limit_beep=1.
//   decel only:
//    - speed_level>0 -> -1, even during overspeed.
//    - speed_level==0 -> no change, limit_beep=1.
//   accel and decel in the same cycle: both ignored, no beep.
//  Downshift (max_level < speed_level): no instant clamp; overspeed=1.
//   Decay counter counts tick_1khz; every DECAY_TICKS ticks speed_level decrements by 1.
//   A decel pulse also decrements and restarts the decay counter.
//   overspeed clears on the cycle speed_level<=max_level; the decay counter is then zeroed.
//   Upshift during overspeed clears it the same way.
//  Duty ramp FSM, states HOLD / RAMP_UP / RAMP_DOWN:
//   HOLD: duty_cmd==duty_tgt. Go to RAMP_UP if tgt>cmd, RAMP_DOWN if tgt<cmd.
//   RAMP_*: every RAMP_TICKS ticks, step duty_cmd by 1 toward duty_tgt.
//    Return to HOLD when equal.
//    A target reversal mid-ramp switches direction directly; the tick counter is kept.
//   ramp_busy = (state != HOLD).
//  Widths: level math in 5 bits so no wrap at 0/15; duty_tgt saturates at 255.
//  Reset mid-ramp or mid-decay: all state returns to reset values on the next edge.
// STRUCTURE
//  speed_pkg: MAX_LEVEL, GEAR_STEP, DUTY_STEP, ramp_state_t enum {HOLD, RAMP_UP, RAMP_DOWN},
//   function gear_ceiling(g) (shared with the gear 7-seg driver).
//  Sub-module duty_ramp: duty_tgt in, duty_cmd/ramp_busy out, holds the FSM and the RAMP_TICKS counter.
//  Top level holds the level register, ceiling register, decay counter and beep logic.
// TESTING
//  1. gear=6, 12 accel pulses -> speed 11, 12th pulse gives limit_beep=1, speed stays 11.
//  2. speed=0, decel pulse -> speed 0, limit_beep=1 for exactly 1 cycle.
//  3. accel+decel same cycle at speed 5 -> speed 5, no beep.
//  4. speed 11 at g6, switch to g2 (max 3):
//     overspeed=1, accel rejected with beep; speed 10 after 200 ticks;
//     reaches 3 after 1600 ticks; overspeed=0.
//  5. speed 0->4 -> duty_tgt 64; duty_cmd +1 every 4 ticks, reaches 64 after 256 ticks; ramp_busy then 0.
//  6. rst asserted mid-ramp (duty_cmd=30) and mid-decay -> all outputs 0 next cycle, FSM HOLD.

Source files
------------

// File: rtl/speed_level_ctrl_pkg.sv
// Shared constants, ramp FSM state type and gear/duty helper functions for the
// speed-level controller and the gear 7-seg driver.
package speed_pkg;

  localparam int MAX_LEVEL   = 15;
  localparam int GEAR_STEP   = 2;
  localparam int DUTY_STEP   = 16;
  localparam int RAMP_TICKS  = 4;
  localparam int DECAY_TICKS = 200;

  typedef enum logic [1:0] {
    HOLD      = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2
  } ramp_state_t;

  function automatic logic [3:0] gear_ceiling(input logic [2:0] g);
    int c;
    if (g == 3'd0) begin
      c = 0;
    end else begin
      c = 1 + GEAR_STEP * (int'(g) - 1);
      if (c > MAX_LEVEL) c = MAX_LEVEL;
    end
    return 4'(c);
  endfunction

  function automatic logic [7:0] level_to_duty(input logic [4:0] lvl);
    int d;
    d = int'(lvl) * DUTY_STEP;
    if (d > 255) d = 255;
    return 8'(d);
  endfunction

endpackage

// File: rtl/speed_level_ctrl_if.sv
// Pulse/gear inputs and level/duty outputs of the speed-level controller.
interface speed_level_ctrl_if;
  logic       tick_1khz;
  logic       accel_pulse;
  logic       decel_pulse;
  logic [2:0] gear_sw;
  logic [3:0] speed_level;
  logic [3:0] max_level;
  logic       overspeed;
  logic       limit_beep;
  logic [7:0] duty_cmd;
  logic       ramp_busy;

  modport master (
    output tick_1khz, accel_pulse, decel_pulse, gear_sw,
    input  speed_level, max_level, overspeed, limit_beep, duty_cmd, ramp_busy
  );

  modport slave (
    input  tick_1khz, accel_pulse, decel_pulse, gear_sw,
    output speed_level, max_level, overspeed, limit_beep, duty_cmd, ramp_busy
  );
endinterface

// File: rtl/speed_level_ctrl_duty_ramp.sv
// Slews the servo duty command one count per RAMP_TICKS ticks toward the target.
import speed_pkg::*;

module duty_ramp (
  input  logic       clk_50mhz,
  input  logic       rst,
  input  logic       i_tick,
  input  logic [7:0] i_duty_tgt,
  output logic [7:0] o_duty_cmd,
  output logic       o_ramp_busy
);
  localparam int CW = $clog2(RAMP_TICKS);
  localparam logic [CW-1:0] TICK_LAST = CW'(RAMP_TICKS - 1);

  ramp_state_t   r_state, w_state_next;
  logic [7:0]    r_duty, w_duty_next, w_duty_step;
  logic [CW-1:0] r_tick_cnt, w_tick_next;
  logic          w_up;

  assign w_up        = i_duty_tgt > r_duty;
  assign w_duty_step = w_up ? r_duty + 8'd1 : r_duty - 8'd1;

  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      r_state    <= HOLD;
      r_duty     <= 8'd0;
      r_tick_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_duty     <= w_duty_next;
      r_tick_cnt <= w_tick_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_duty_next  = r_duty;
    w_tick_next  = r_tick_cnt;
    case (r_state)
      HOLD: begin
        w_tick_next = '0;
        if (i_duty_tgt > r_duty)      w_state_next = RAMP_UP;
        else if (i_duty_tgt < r_duty) w_state_next = RAMP_DOWN;
      end
      default: begin
        if (i_duty_tgt == r_duty) begin
          w_state_next = HOLD;
          w_tick_next  = '0;
        end else begin
          // Direction follows the live target; the tick phase survives a reversal.
          w_state_next = w_up ? RAMP_UP : RAMP_DOWN;
          if (i_tick) begin
            if (r_tick_cnt == TICK_LAST) begin
              w_tick_next = '0;
              w_duty_next = w_duty_step;
              if (w_duty_step == i_duty_tgt) w_state_next = HOLD;
            end else begin
              w_tick_next = r_tick_cnt + 1'b1;
            end
          end
        end
      end
    endcase
  end

  assign o_duty_cmd  = r_duty;
  assign o_ramp_busy = (r_state != HOLD);
endmodule

// File: rtl/speed_level_ctrl.sv
// Speed level register with gear ceiling, limit beep and engine-brake decay;
// feeds the duty ramp that drives the servo PWM.
import speed_pkg::*;

module speed_level_ctrl (
  input  logic clk_50mhz,
  input  logic rst,
  speed_level_ctrl_if.slave bus
);
  localparam int DW = $clog2(DECAY_TICKS);
  localparam logic [DW-1:0] DECAY_LAST = DW'(DECAY_TICKS - 1);

  logic [4:0]    r_level, w_level_next;
  logic [3:0]    r_max;
  logic          r_beep, w_beep_next;
  logic [DW-1:0] r_decay_cnt, w_decay_next;
  logic [4:0]    w_max5;
  logic          w_overspeed, w_acc_only, w_dec_only;
  logic [7:0]    w_duty_tgt;

  assign w_max5      = {1'b0, r_max};
  assign w_overspeed = r_level > w_max5;
  assign w_acc_only  = bus.accel_pulse & ~bus.decel_pulse;
  assign w_dec_only  = bus.decel_pulse & ~bus.accel_pulse;

  always_comb begin
    w_level_next = r_level;
    w_beep_next  = 1'b0;
    w_decay_next = r_decay_cnt;
    if (w_acc_only) begin
      if (r_level < w_max5) w_level_next = r_level + 5'd1;
      else                  w_beep_next  = 1'b1;
    end else if (w_dec_only) begin
      if (r_level != 5'd0) w_level_next = r_level - 5'd1;
      else                 w_beep_next  = 1'b1;
    end
    // Overspeed implies level >= 1, so a decel and a decay step never both apply.
    if (!w_overspeed) begin
      w_decay_next = '0;
    end else if (w_dec_only) begin
      w_decay_next = '0;
    end else if (bus.tick_1khz) begin
      if (r_decay_cnt == DECAY_LAST) begin
        w_decay_next = '0;
        w_level_next = r_level - 5'd1;
      end else begin
        w_decay_next = r_decay_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      r_level     <= 5'd0;
      r_max       <= 4'd0;
      r_beep      <= 1'b0;
      r_decay_cnt <= '0;
    end else begin
      r_level     <= w_level_next;
      r_max       <= gear_ceiling(bus.gear_sw);
      r_beep      <= w_beep_next;
      r_decay_cnt <= w_decay_next;
    end
  end

  assign w_duty_tgt      = level_to_duty(r_level);
  assign bus.speed_level = r_level[3:0];
  assign bus.max_level   = r_max;
  assign bus.overspeed   = w_overspeed;
  assign bus.limit_beep  = r_beep;

  duty_ramp u_duty_ramp (
    .clk_50mhz   (clk_50mhz),
    .rst         (rst),
    .i_tick      (bus.tick_1khz),
    .i_duty_tgt  (w_duty_tgt),
    .o_duty_cmd  (bus.duty_cmd),
    .o_ramp_busy (bus.ramp_busy)
  );
endmodule
